down_timer60: RTL and testbench
===============================

Name: down_timer60

Overview:
- Settable 0–59 s countdown timer for the DE0-CV board; the count-down counterpart to the existing 60-second up-counter.
- Takes three raw push-buttons: start/pause, set-tens and set-ones.
- Counts down at 1 Hz, displays tens/ones on HEX1/HEX0 through the existing seg7dec decoder, and raises LED_DONE on reaching 00.
- Sits at top level beside the up-counter; no bus interface.

Parameters:
- CLK_FREQ, 50_000_000, CLK cycles per 1 s tick.
- DB_CYCLES, 500_000, button sample interval in CLK cycles (10 ms at 50 MHz).
- BLINK_CYCLES, 12_500_000, LED_DONE half-period in CLK cycles (2 Hz blink).

Ports:
- CLK  input  1  system clock, 50 MHz.
- RST  input  1  reset, synchronous, active-high.
- KEY_START  input  1  raw button, active-low, asynchronous; start/pause/acknowledge.
- KEY_TEN  input  1  raw button, active-low, asynchronous; increments tens preset.
- KEY_ONE  input  1  raw button, active-low, asynchronous; increments ones preset.
- HEX1  output  7  tens digit segments, seg7dec encoding.
- HEX0  output  7  ones digit segments, seg7dec encoding.
- LED_DONE  output  1  high while blinking in DONE state.

Behaviour:
- Reset is RST, synchronous, active-high; clock is CLK.
- Reset values:
  - state=IDLE; preset=00; count=00.
  - Prescaler, blink counter and debounce state all 0.
  - LED_DONE=0; HEX shows "00".
- Button front end, one per key:
  - 2-FF synchronizer, then inversion to active-high.
  - Sampled once per DB_CYCLES (shared sample-enable counter).
  - A press is two consecutive samples high after a low sample.
  - Each press emits exactly one 1-CLK pulse.
  - Holding a key produces no repeat.
  - Latency from stable press to pulse is ≤ 2*DB_CYCLES+3 CLK.
- Digits are BCD: tens 3 bits (0–5), ones 4 bits (0–9). Display shows count in all states.
- IDLE:
  - count mirrors preset.
  - ten_pulse: tens +1, wraps 5→0.
  - one_pulse: ones +1, wraps 9→0, no carry into tens.
  - ten_pulse and one_pulse in the same cycle: both apply.
  - start_pulse with preset≠00: count←preset, prescaler←0, go RUN.
  - start_pulse with preset=00: ignored, stay IDLE.
- RUN:
  - Prescaler counts 0..CLK_FREQ-1; tick on terminal value. First tick is exactly CLK_FREQ cycles after entry.
  - On tick, BCD decrement: ones 0→9 with tens -1; otherwise ones -1.
  - If count=01 at the tick, count←00 and go DONE in the same edge.
  - start_pulse: go PAUSE and freeze the prescaler. Pause wins over a coincident tick: no decrement.
  - Set pulses are ignored.
- PAUSE:
  - count and prescaler held.
  - start_pulse resumes RUN from the held prescaler value.
  - Set pulses are ignored.
- DONE:
  - count=00.
  - LED_DONE toggles every BLINK_CYCLES; starts at 1 on entry.
  - start_pulse: LED_DONE←0, blink counter←0, count←preset, go IDLE. Preset is retained for repeat runs.
- No other transitions. RST in any state returns everything to reset values on the next edge, including mid-debounce and mid-RUN.
- HEX outputs are combinational from count via seg7dec. LED_DONE is registered.

Decomposition:
- Shared package/header holds:
  - State encodings: ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3.
  - BCD limits: TEN_MAX=3'd5, ONE_MAX=4'd9.
- Sub-module key_pulse covers synchronizer, debounce sampling and edge pulse for one key. It is instantiated three times and shares the sample-enable input from the parent.
- The two seg7dec instances are reused unchanged.

Test Plan (sim with CLK_FREQ=100, DB_CYCLES=4, BLINK_CYCLES=10):
- Preset wrap: RST, then 7 KEY_TEN presses and 12 KEY_ONE presses (each held 20 CLK) -> preset tens=1, ones=2, HEX shows "12". A key held 200 CLK yields exactly one increment.
- Basic countdown: preset 03, start -> count 02 at entry+100 CLK, 01 at +200, 00 at +300. State DONE and LED_DONE=1 on the same edge; LED toggles every 10 CLK thereafter.
- Borrow: preset 10, start -> after first tick count=09. After 10 ticks count=00 and DONE.
- Pause/resume: preset 05, start, pause at entry+150 (prescaler=50), wait 500 CLK -> count still 04. Resume -> next tick 50 CLK after resume, count=03.
- Boundary and ignore rules:
  - Start with preset 00 -> stays IDLE.
  - Set presses during RUN -> preset and count unchanged.
  - Pause pulse coinciding with tick -> no decrement.
- Reset and reload:
  - RST asserted mid-RUN at count 02 -> next edge IDLE, preset=00, count=00, LED_DONE=0.
  - In DONE, start press -> IDLE with count reloaded to the last preset.

Source files
------------

// File: rtl/down_timer60_pkg.sv
// Shared types and BCD helpers for the 0-59 s countdown timer.
package down_timer60_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] TEN_MAX = 3'd5;
   localparam logic [3:0] ONE_MAX = 4'd9;

   typedef struct packed {
      logic [2:0] ten;
      logic [3:0] one;
   } bcd_t;

   localparam bcd_t BCD_01 = '{ten: 3'd0, one: 4'd1};

   function automatic logic [2:0] ten_inc(input logic [2:0] v);
      return (v == TEN_MAX) ? 3'd0 : v + 3'd1;
   endfunction

   function automatic logic [3:0] one_inc(input logic [3:0] v);
      return (v == ONE_MAX) ? 4'd0 : v + 4'd1;
   endfunction

   function automatic bcd_t bcd_dec(input bcd_t v);
      bcd_t r;
      r = v;
      if (v.one == 4'd0) begin
         r.one = ONE_MAX;
         r.ten = v.ten - 3'd1;
      end else begin
         r.one = v.one - 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/down_timer60_key_pulse.sv
// One push-button front end: synchronizer, slow-sampled debounce, single press pulse.
module key_pulse (
   input  logic CLK,
   input  logic RST,
   input  logic key_n,
   input  logic sample_en,
   output logic pulse
);

   logic [1:0] sync_q;
   logic [2:0] hist_q;
   logic       key_act;
   logic [2:0] hist_nxt;

   assign key_act  = ~sync_q[1];
   assign hist_nxt = {hist_q[1:0], key_act};

   // A press is one low sample followed by two high samples, so holding never repeats.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q <= 2'b11;
         hist_q <= 3'b000;
         pulse  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], key_n};
         pulse  <= 1'b0;
         if (sample_en) begin
            hist_q <= hist_nxt;
            pulse  <= (hist_nxt == 3'b011);
         end
      end
   end

endmodule

// File: rtl/seg7dec.sv
// Hex digit to active-low 7-segment pattern (gfedcba), shared by the board tops.
module seg7dec (
   input  logic [3:0] num,
   output logic [6:0] hex
);

   always_comb begin
      hex = 7'b1111111;
      case (num)
         4'h0: hex = 7'b1000000;
         4'h1: hex = 7'b1111001;
         4'h2: hex = 7'b0100100;
         4'h3: hex = 7'b0110000;
         4'h4: hex = 7'b0011001;
         4'h5: hex = 7'b0010010;
         4'h6: hex = 7'b0000010;
         4'h7: hex = 7'b1011000;
         4'h8: hex = 7'b0000000;
         4'h9: hex = 7'b0010000;
         4'ha: hex = 7'b0001000;
         4'hb: hex = 7'b0000011;
         4'hc: hex = 7'b1000110;
         4'hd: hex = 7'b0100001;
         4'he: hex = 7'b0000110;
         4'hf: hex = 7'b0001110;
         default: hex = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/down_timer60.sv
// Settable 0-59 s countdown timer: three buttons in, two 7-seg digits and a done LED out.
//
// state    | meaning
// ST_IDLE  | preset editable, count mirrors preset
// ST_RUN   | prescaler running, count decrements once per second
// ST_PAUSE | count and prescaler frozen
// ST_DONE  | count is 00, LED_DONE blinking until acknowledged
module down_timer60
   import down_timer60_pkg::*;
#(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int DB_CYCLES    = 500_000,
   parameter int BLINK_CYCLES = 12_500_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       KEY_START,
   input  logic       KEY_TEN,
   input  logic       KEY_ONE,
   output logic [6:0] HEX1,
   output logic [6:0] HEX0,
   output logic       LED_DONE
);

   localparam int PRESC_W = $clog2(CLK_FREQ);
   localparam int DB_W    = $clog2(DB_CYCLES);
   localparam int BLINK_W = $clog2(BLINK_CYCLES);

   localparam logic [PRESC_W-1:0] PRESC_TC  = PRESC_W'(CLK_FREQ - 1);
   localparam logic [DB_W-1:0]    DB_RELOAD = DB_W'(DB_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_TC  = BLINK_W'(BLINK_CYCLES - 1);

   logic [DB_W-1:0] db_cnt_q;
   logic            sample_en;
   logic            start_pulse;
   logic            ten_pulse;
   logic            one_pulse;

   state_t               state_q,  state_d;
   bcd_t                 preset_q, preset_d;
   bcd_t                 count_q,  count_d;
   logic [PRESC_W-1:0]   presc_q,  presc_d;
   logic [BLINK_W-1:0]   blink_q,  blink_d;
   logic                 led_q,    led_d;

   assign sample_en = (db_cnt_q == '0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         db_cnt_q <= '0;
      end else if (sample_en) begin
         db_cnt_q <= DB_RELOAD;
      end else begin
         db_cnt_q <= db_cnt_q - DB_W'(1);
      end
   end

   key_pulse u_key_start (
      .CLK       (CLK),
      .RST       (RST),
      .key_n     (KEY_START),
      .sample_en (sample_en),
      .pulse     (start_pulse)
   );

   key_pulse u_key_ten (
      .CLK       (CLK),
      .RST       (RST),
      .key_n     (KEY_TEN),
      .sample_en (sample_en),
      .pulse     (ten_pulse)
   );

   key_pulse u_key_one (
      .CLK       (CLK),
      .RST       (RST),
      .key_n     (KEY_ONE),
      .sample_en (sample_en),
      .pulse     (one_pulse)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         preset_q <= '0;
         count_q  <= '0;
         presc_q  <= '0;
         blink_q  <= '0;
         led_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         presc_q  <= presc_d;
         blink_q  <= blink_d;
         led_q    <= led_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      preset_d = preset_q;
      count_d  = count_q;
      presc_d  = presc_q;
      blink_d  = blink_q;
      led_d    = led_q;
      case (state_q)
         ST_IDLE: begin
            if (ten_pulse) preset_d.ten = ten_inc(preset_q.ten);
            if (one_pulse) preset_d.one = one_inc(preset_q.one);
            count_d = preset_d;
            if (start_pulse && (preset_q != '0)) begin
               count_d = preset_q;
               presc_d = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Pause takes priority: the prescaler freezes even on its terminal value.
            if (start_pulse) begin
               state_d = ST_PAUSE;
            end else if (presc_q == PRESC_TC) begin
               presc_d = '0;
               if (count_q == BCD_01) begin
                  count_d = '0;
                  state_d = ST_DONE;
                  led_d   = 1'b1;
                  blink_d = '0;
               end else begin
                  count_d = bcd_dec(count_q);
               end
            end else begin
               presc_d = presc_q + PRESC_W'(1);
            end
         end
         ST_PAUSE: begin
            if (start_pulse) state_d = ST_RUN;
         end
         ST_DONE: begin
            if (start_pulse) begin
               led_d   = 1'b0;
               blink_d = '0;
               count_d = preset_q;
               state_d = ST_IDLE;
            end else if (blink_q == BLINK_TC) begin
               blink_d = '0;
               led_d   = ~led_q;
            end else begin
               blink_d = blink_q + BLINK_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign LED_DONE = led_q;

   seg7dec u_hex1 (
      .num ({1'b0, count_q.ten}),
      .hex (HEX1)
   );

   seg7dec u_hex0 (
      .num (count_q.one),
      .hex (HEX0)
   );

endmodule

// File: tb/tb_down_timer60.sv
// Scoreboard bench for down_timer60: driver queues expected display events, monitor checks them.
module tb_down_timer60;

   localparam int CLK_FREQ     = 100;
   localparam int DB_CYCLES    = 4;
   localparam int BLINK_CYCLES = 10;
   // Window (in cycles after driving a key) in which its debounced effect may appear.
   localparam int PRESS_LO     = DB_CYCLES + 3;
   localparam int PRESS_HI     = 2 * DB_CYCLES + 5;
   localparam int M_WIN        = 0;
   localparam int M_REL        = 1;
   localparam int M_BLINK      = 2;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       KEY_START = 1'b1;
   logic       KEY_TEN = 1'b1;
   logic       KEY_ONE = 1'b1;
   logic [6:0] HEX1;
   logic [6:0] HEX0;
   logic       LED_DONE;

   down_timer60 #(
      .CLK_FREQ     (CLK_FREQ),
      .DB_CYCLES    (DB_CYCLES),
      .BLINK_CYCLES (BLINK_CYCLES)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .KEY_START (KEY_START),
      .KEY_TEN   (KEY_TEN),
      .KEY_ONE   (KEY_ONE),
      .HEX1      (HEX1),
      .HEX0      (HEX0),
      .LED_DONE  (LED_DONE)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int    ten;
      int    one;
      int    led;
      int    mode;
      int    lo;
      int    hi;
      string name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   pt = 0;
   int   po = 0;
   bit   mon_en = 1'b0;
   int   prev_t, prev_o, prev_l, last_evt;
   int   m_t, m_o, m_l;

   function automatic int seg2dig(input logic [6:0] s);
      case (s)
         7'b1000000: return 0;
         7'b1111001: return 1;
         7'b0100100: return 2;
         7'b0110000: return 3;
         7'b0011001: return 4;
         7'b0010010: return 5;
         7'b0000010: return 6;
         7'b1011000: return 7;
         7'b0000000: return 8;
         7'b0010000: return 9;
         default:    return -1;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic push(input string name, input int secs, input int led,
                       input int mode, input int lo, input int hi);
      exp_t e;
      e.ten  = secs / 10;
      e.one  = secs % 10;
      e.led  = led;
      e.mode = mode;
      e.lo   = lo;
      e.hi   = hi;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic on_event(input int ot, input int oo, input int ol);
      exp_t e;
      if (sb.size() > 0 && sb[0].mode == M_BLINK) begin
         if (ot == 0 && oo == 0 && ol != prev_l) begin
            check("blink_period", cyc - last_evt, BLINK_CYCLES);
            return;
         end
         sb.delete(0);
      end
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_event actual=%0d%0d led=%0d required=no change (cycle %0d)",
                  ot, oo, ol, cyc);
         return;
      end
      e = sb.pop_front();
      check({e.name, "_tens"}, ot, e.ten);
      check({e.name, "_ones"}, oo, e.one);
      check({e.name, "_led"}, ol, e.led);
      if (e.mode == M_REL) check({e.name, "_interval"}, cyc - last_evt, e.lo);
      else check_range({e.name, "_cycle"}, cyc, e.lo, e.hi);
   endtask

   always @(negedge CLK) begin
      if (mon_en) begin
         m_t = seg2dig(HEX1);
         m_o = seg2dig(HEX0);
         m_l = int'(LED_DONE);
         if (m_t != prev_t || m_o != prev_o || m_l != prev_l) begin
            on_event(m_t, m_o, m_l);
            prev_t   = m_t;
            prev_o   = m_o;
            prev_l   = m_l;
            last_evt = cyc;
         end
      end
   end

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge CLK);
   endtask

   task automatic press(input bit s, input bit t, input bit o, input int hold);
      if (s) KEY_START = 1'b0;
      if (t) KEY_TEN = 1'b0;
      if (o) KEY_ONE = 1'b0;
      repeat (hold) @(negedge CLK);
      KEY_START = 1'b1;
      KEY_TEN   = 1'b1;
      KEY_ONE   = 1'b1;
      repeat (16) @(negedge CLK);
   endtask

   task automatic set_press(input bit t, input bit o, input int hold);
      int k;
      if (t) pt = (pt + 1) % 6;
      if (o) po = (po + 1) % 10;
      k = cyc;
      push("preset", pt * 10 + po, 0, M_WIN, k + PRESS_LO, k + PRESS_HI);
      press(1'b0, t, o, hold);
   endtask

   task automatic set_preset(input int secs);
      int nt, no;
      nt = (secs / 10 - pt + 6) % 6;
      no = (secs % 10 - po + 10) % 10;
      while (nt > 0 || no > 0) begin
         set_press(nt > 0, no > 0, 20);
         if (nt > 0) nt--;
         if (no > 0) no--;
      end
   endtask

   task automatic exit_done(input int secs);
      int k;
      k = cyc;
      push("reload", secs, 0, M_WIN, k + PRESS_LO, k + PRESS_HI);
      press(1'b1, 1'b0, 1'b0, 20);
   endtask

   // Full countdown from secs to 00, with set presses issued while running.
   task automatic run_full(input int secs);
      int k;
      set_preset(secs);
      k = cyc;
      for (int n = secs - 1; n >= 0; n--) begin
         if (n == secs - 1)
            push("first_tick", n, int'(n == 0), M_WIN, k + CLK_FREQ + PRESS_LO, k + CLK_FREQ + PRESS_HI);
         else
            push("tick", n, int'(n == 0), M_REL, CLK_FREQ, 0);
      end
      push("blink", 0, 1, M_BLINK, 0, 0);
      press(1'b1, 1'b0, 1'b0, 20);
      press(1'b0, 1'b1, 1'b0, 20);
      press(1'b0, 1'b0, 1'b1, 20);
      wait_to(k + PRESS_HI + secs * CLK_FREQ + 4 * BLINK_CYCLES + int'($urandom_range(0, 9)));
      exit_done(secs);
   endtask

   initial begin
      int k, d, secs;
      bit rt, ro;

      repeat (3) @(negedge CLK);
      check("reset_hex1", seg2dig(HEX1), 0);
      check("reset_hex0", seg2dig(HEX0), 0);
      check("reset_led", int'(LED_DONE), 0);
      RST      = 1'b0;
      prev_t   = 0;
      prev_o   = 0;
      prev_l   = 0;
      last_evt = cyc;
      mon_en   = 1'b1;

      // Preset wrap: 7 tens presses and 12 ones presses give 12.
      repeat (7) set_press(1'b1, 1'b0, 20);
      repeat (12) set_press(1'b0, 1'b1, 20);
      check("preset_wrap_display", seg2dig(HEX1) * 10 + seg2dig(HEX0), 12);
      set_press(1'b0, 1'b1, 200);
      set_press(1'b1, 1'b1, 20);
      repeat (6) begin
         rt = 1'(($urandom_range(0, 2)) != 0);
         ro = rt ? 1'($urandom_range(0, 1)) : 1'b1;
         set_press(rt, ro, int'($urandom_range(14, 40)));
      end

      run_full(3);
      run_full(10);
      run_full(int'($urandom_range(1, 15)));

      // Pause after the first tick, hold, resume.
      set_preset(5);
      k = cyc;
      d = 4 * int'($urandom_range(50, 90));
      push("pause_first_tick", 4, 0, M_WIN, k + CLK_FREQ + PRESS_LO, k + CLK_FREQ + PRESS_HI);
      // Both the pause edge and the resume edge hold the prescaler.
      push("resume_tick", 3, 0, M_REL, CLK_FREQ + d + 1, 0);
      push("tick", 2, 0, M_REL, CLK_FREQ, 0);
      push("tick", 1, 0, M_REL, CLK_FREQ, 0);
      push("tick", 0, 1, M_REL, CLK_FREQ, 0);
      push("blink", 0, 1, M_BLINK, 0, 0);
      press(1'b1, 1'b0, 1'b0, 20);
      wait_to(k + 150);
      press(1'b1, 1'b0, 1'b0, 20);
      press(1'b0, 1'b1, 1'b0, 20);
      wait_to(k + 150 + d);
      press(1'b1, 1'b0, 1'b0, 20);
      wait_to(k + PRESS_HI + 5 * CLK_FREQ + d + 1 + 4 * BLINK_CYCLES);
      exit_done(5);

      // Pause press in the same phase as start, so it lands exactly on the first tick.
      set_preset(2);
      k = cyc;
      d = 4 * int'($urandom_range(10, 40));
      push("held_tick", 1, 0, M_WIN, k + CLK_FREQ + PRESS_LO + d + 1, k + CLK_FREQ + PRESS_HI + d + 1);
      push("tick", 0, 1, M_REL, CLK_FREQ, 0);
      push("blink", 0, 1, M_BLINK, 0, 0);
      press(1'b1, 1'b0, 1'b0, 20);
      wait_to(k + CLK_FREQ);
      press(1'b1, 1'b0, 1'b0, 20);
      wait_to(k + CLK_FREQ + d);
      press(1'b1, 1'b0, 1'b0, 20);
      wait_to(k + PRESS_HI + 2 * CLK_FREQ + d + 1 + 4 * BLINK_CYCLES);
      exit_done(2);

      // Reset in the middle of a run at count 02.
      secs = 3;
      set_preset(secs);
      k = cyc;
      push("pre_reset_tick", 2, 0, M_WIN, k + CLK_FREQ + PRESS_LO, k + CLK_FREQ + PRESS_HI);
      press(1'b1, 1'b0, 1'b0, 20);
      wait_to(k + CLK_FREQ + PRESS_HI + 40);
      push("mid_run_reset", 0, 0, M_WIN, cyc + 1, cyc + 1);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      pt  = 0;
      po  = 0;
      repeat (10) @(negedge CLK);
      press(1'b1, 1'b0, 1'b0, 20);
      repeat (CLK_FREQ + 20) @(negedge CLK);
      check("zero_start_hex", seg2dig(HEX1) * 10 + seg2dig(HEX0), 0);
      check("zero_start_led", int'(LED_DONE), 0);

      repeat (20) @(negedge CLK);
      mon_en = 1'b0;
      while (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL missing_event %s actual=none required=%0d%0d led=%0d",
                  sb[0].name, sb[0].ten, sb[0].one, sb[0].led);
         sb.delete(0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
